wb_cmd_master: RTL and testbench

//  Wishbone classic (B4, non-pipelined) master: the initiator that drives a wbs_* slave port such as the user area.

---
 rtl/wb_cmd_master.sv | 122 ++++++++++++
 tb/tb_wb_cmd_master.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: Wishbone classic (B4) single-transaction master.
// A valid/ready command becomes one bus cycle. The result comes back on a
// valid/ready response port.
// Optional build macro WB_TIMEOUT_EN: aborts a bus cycle that gets no ack/err
// within TIMEOUT_CYCLES and returns an error response.
module wb_cmd_master #(
  parameter int ADR_W          = 32,
  parameter int DAT_W          = 32,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int SEL_W         = DAT_W/8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_we_i,
  input  logic [ADR_W-1:0] cmd_adr_i,
  input  logic [DAT_W-1:0] cmd_dat_i,
  input  logic [SEL_W-1:0] cmd_sel_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [DAT_W-1:0] rsp_dat_o,
  output logic             rsp_err_o,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [SEL_W-1:0] wbm_sel_o,
  output logic [ADR_W-1:0] wbm_adr_o,
  output logic [DAT_W-1:0] wbm_dat_o,
  input  logic [DAT_W-1:0] wbm_dat_i,
  input  logic             wbm_ack_i,
  input  logic             wbm_err_i
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  state_t state, state_nxt;

  // ack/err only matter while in BUS; outside it they are ignored
  logic term;
  logic abort;
  assign term = wbm_ack_i | wbm_err_i;

`ifdef WB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES < 256) ? 8 : 16;
  logic [CNT_W-1:0] to_cnt;

  // Wait counter: zero while idle so it starts at 0 on BUS entry
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)                    to_cnt <= '0;
    else if (state != BUS)           to_cnt <= '0;
    else if (!term)                  to_cnt <= to_cnt + 1'b1;
  end

  // Limit hit on this edge with no termination; a same-edge ack wins
  assign abort = (state == BUS) && !term &&
                 (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign abort = 1'b0;
`endif

  // State register; async reset drops cyc/stb immediately
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (cmd_valid_i)    state_nxt = BUS;
      BUS:     if (term || abort)  state_nxt = RESP;
      RESP:    if (rsp_ready_i)    state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  // Handshake and bus strobes decoded from the registered state
  always_comb begin
    cmd_ready_o = 1'b0;
    wbm_cyc_o   = 1'b0;
    wbm_stb_o   = 1'b0;
    rsp_valid_o = 1'b0;
    unique case (state)
      IDLE:    cmd_ready_o = 1'b1;
      BUS:     begin wbm_cyc_o = 1'b1; wbm_stb_o = 1'b1; end
      RESP:    rsp_valid_o = 1'b1;
      default: ;
    endcase
  end

  // Command latch and response capture
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      rsp_dat_o <= '0;
      rsp_err_o <= 1'b0;
    end else begin
      if (state == IDLE && cmd_valid_i) begin
        wbm_we_o  <= cmd_we_i;
        wbm_sel_o <= cmd_sel_i;
        wbm_adr_o <= cmd_adr_i;
        wbm_dat_o <= cmd_dat_i;
      end
      if (state == BUS && (term || abort)) begin
        // Only a clean ack counts as success; err, ack+err or timeout is an error
        rsp_err_o <= !(wbm_ack_i && !wbm_err_i);
        rsp_dat_o <= (wbm_ack_i && !wbm_err_i && !wbm_we_o) ? wbm_dat_i : '0;
      end
      if (state == RESP && rsp_ready_i) begin
        rsp_dat_o <= '0;
        rsp_err_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master with a small scripted Wishbone slave and a
// response scoreboard. Define WB_TIMEOUT_EN to also exercise the timeout path.
module tb_wb_cmd_master;

  localparam int ADR_W = 32;
  localparam int DAT_W = 32;
  localparam int SEL_W = DAT_W/8;

  localparam int M_NONE = 0, M_ACK = 1, M_ERR = 2, M_BOTH = 3;

  logic             wb_clk_i = 1'b0;
  logic             wb_rst_i = 1'b1;
  logic             cmd_valid_i = 1'b0;
  logic             cmd_ready_o;
  logic             cmd_we_i = 1'b0;
  logic [ADR_W-1:0] cmd_adr_i = '0;
  logic [DAT_W-1:0] cmd_dat_i = '0;
  logic [SEL_W-1:0] cmd_sel_i = '0;
  logic             rsp_valid_o;
  logic             rsp_ready_i = 1'b0;
  logic [DAT_W-1:0] rsp_dat_o;
  logic             rsp_err_o;
  logic             wbm_cyc_o;
  logic             wbm_stb_o;
  logic             wbm_we_o;
  logic [SEL_W-1:0] wbm_sel_o;
  logic [ADR_W-1:0] wbm_adr_o;
  logic [DAT_W-1:0] wbm_dat_o;
  logic [DAT_W-1:0] wbm_dat_i = '0;
  logic             wbm_ack_i = 1'b0;
  logic             wbm_err_i = 1'b0;

  wb_cmd_master #(.ADR_W(ADR_W), .DAT_W(DAT_W), .TIMEOUT_CYCLES(4)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_we_i(cmd_we_i), .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i),
    .cmd_sel_i(cmd_sel_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int ntests = 0;
  int nfail  = 0;

  typedef struct { logic [DAT_W-1:0] dat; logic err; } rsp_t;
  rsp_t sb[$];

  // Scripted slave: answers on the s_wait-th cycle of stb with s_mode
  int               s_mode  = M_ACK;
  int               s_wait  = 1;
  logic [DAT_W-1:0] s_rdata = '0;
  int               stbcnt  = 0;
  int               last_stb = 0;
  logic             cap_we  = 1'b0;
  logic [ADR_W-1:0] cap_adr = '0;
  logic [DAT_W-1:0] cap_dat = '0;
  logic [SEL_W-1:0] cap_sel = '0;

  always @(negedge wb_clk_i) begin
    if (wbm_cyc_o && wbm_stb_o) begin
      stbcnt = stbcnt + 1;
      if (stbcnt == 1) begin
        cap_we = wbm_we_o; cap_adr = wbm_adr_o; cap_dat = wbm_dat_o; cap_sel = wbm_sel_o;
      end
      wbm_ack_i = (s_mode == M_ACK || s_mode == M_BOTH) && (stbcnt == s_wait);
      wbm_err_i = (s_mode == M_ERR || s_mode == M_BOTH) && (stbcnt == s_wait);
      wbm_dat_i = s_rdata;
    end else begin
      if (stbcnt != 0) last_stb = stbcnt;
      stbcnt    = 0;
      wbm_ack_i = 1'b0;
      wbm_err_i = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command and push the spec-derived expected response
  task automatic send(input logic we, input logic [ADR_W-1:0] adr,
                      input logic [DAT_W-1:0] dat, input logic [SEL_W-1:0] sel,
                      input int mode, input int wt, input logic [DAT_W-1:0] rdata);
    rsp_t e;
    s_mode = mode; s_wait = wt; s_rdata = rdata;
    e.err = (mode != M_ACK);
    e.dat = (mode == M_ACK && !we) ? rdata : '0;
    sb.push_back(e);
    @(negedge wb_clk_i);
    chk("cmd_ready_idle", cmd_ready_o, 1);
    cmd_valid_i = 1'b1; cmd_we_i = we; cmd_adr_i = adr; cmd_dat_i = dat; cmd_sel_i = sel;
    @(negedge wb_clk_i);
    cmd_valid_i = 1'b0;
  endtask

  // Wait for the response, optionally stall it, then compare with the scoreboard
  task automatic collect(input string tag, input int hold, input int exp_stb);
    rsp_t e;
    int k = 0;
    while (!rsp_valid_o && k < 40) begin @(negedge wb_clk_i); k++; end
    chk({tag, "_rsp_seen"}, rsp_valid_o, 1);
    e = sb.pop_front();
    for (int i = 0; i < hold; i++) begin
      chk({tag, "_hold_valid"}, rsp_valid_o, 1);
      chk({tag, "_hold_dat"}, rsp_dat_o, e.dat);
      chk({tag, "_hold_noready"}, cmd_ready_o, 0);
      chk({tag, "_hold_nocyc"}, wbm_cyc_o, 0);
      @(negedge wb_clk_i);
    end
    chk({tag, "_dat"}, rsp_dat_o, e.dat);
    chk({tag, "_err"}, rsp_err_o, e.err);
    chk({tag, "_cyc_low"}, wbm_cyc_o, 0);
    rsp_ready_i = 1'b1;
    @(negedge wb_clk_i);
    rsp_ready_i = 1'b0;
    chk({tag, "_valid_drop"}, rsp_valid_o, 0);
    chk({tag, "_ready_back"}, cmd_ready_o, 1);
    if (exp_stb > 0) chk({tag, "_stb_cycles"}, last_stb, exp_stb);
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_cmd_ready", cmd_ready_o, 1);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_cyc", wbm_cyc_o, 0);
    chk("rst_stb", wbm_stb_o, 0);
    chk("rst_rsp_dat", rsp_dat_o, 0);
    chk("rst_adr", wbm_adr_o, 0);
    @(negedge wb_clk_i); @(negedge wb_clk_i);
    wb_rst_i = 1'b0;

    // 1: write, ack on 2nd stb cycle
    send(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF, M_ACK, 2, 32'h5555_5555);
    collect("wr", 0, 2);
    chk("wr_we", cap_we, 1);
    chk("wr_adr", cap_adr, 32'h3000_0004);
    chk("wr_dat", cap_dat, 32'hA5A5_1234);
    chk("wr_sel", cap_sel, 4'hF);

    // 2: read, zero-wait ack
    send(1'b0, 32'h3000_0000, 32'h0, 4'hF, M_ACK, 1, 32'hDEAD_BEEF);
    collect("rd", 0, 1);
    chk("rd_we", cap_we, 0);

    // 3: ack and err together -> error
    send(1'b0, 32'h3000_0008, 32'h0, 4'h3, M_BOTH, 1, 32'h1111_2222);
    collect("both", 0, 1);

    // plain err on a write
    send(1'b1, 32'h3000_000C, 32'h7777_0000, 4'h1, M_ERR, 3, 32'h0);
    collect("err", 0, 3);

    // 4: response stalled for 5 cycles
    send(1'b0, 32'h3000_0010, 32'h0, 4'hF, M_ACK, 1, 32'hCAFE_F00D);
    collect("stall", 5, 1);

`ifdef WB_TIMEOUT_EN
    // 5: no answer -> abort after 4 stb cycles; then ack right at the limit
    send(1'b0, 32'h3000_0014, 32'h0, 4'hF, M_NONE, 1, 32'h0);
    collect("tmo", 0, 4);
    send(1'b0, 32'h3000_0018, 32'h0, 4'hF, M_ACK, 4, 32'h0BAD_CAFE);
    collect("tmo_ack", 0, 4);
`endif

    // 6: reset mid-BUS drops the bus without a clock edge
    s_mode = M_NONE; s_wait = 1;
    @(negedge wb_clk_i);
    cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_adr_i = 32'h3000_0020; cmd_dat_i = 32'h1;
    @(negedge wb_clk_i);
    cmd_valid_i = 1'b0;
    @(negedge wb_clk_i);
    chk("mid_cyc_high", wbm_cyc_o, 1);
    #2 wb_rst_i = 1'b1;
    #1;
    chk("mid_rst_cyc", wbm_cyc_o, 0);
    chk("mid_rst_stb", wbm_stb_o, 0);
    chk("mid_rst_rsp_valid", rsp_valid_o, 0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    chk("post_rst_ready", cmd_ready_o, 1);
    chk("post_rst_no_rsp", rsp_valid_o, 0);
    send(1'b0, 32'h3000_0024, 32'h0, 4'hF, M_ACK, 2, 32'h1357_9BDF);
    collect("post_rst", 0, 2);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
